// File: rtl/iob_eth_mii_tx_framer.sv
// MII transmit framer: preamble/SFD, payload from the TX buffer, zero padding,
// CRC-32 FCS and inter-packet gap, all in the MTxClk domain.
module iob_eth_mii_tx_framer #(
    parameter int BUFFER_W = 11,
    parameter int MIN_LEN  = 60,
    parameter int IPG_CYC  = 24
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                send_i,
    input  logic [10:0]         nbytes_i,
    input  logic                crc_en_i,
    output logic                ready_o,
    output logic                done_o,
    output logic [BUFFER_W-1:0] addr_o,
    input  logic [7:0]          data_i,
    output logic                tx_en_o,
    output logic [3:0]          tx_data_o
);

    localparam logic [10:0] MIN_LEN_W = 11'(MIN_LEN);
    localparam logic [10:0] IPG_LAST  = 11'(IPG_CYC - 1);
    localparam logic [31:0] CRC_POLY  = 32'hEDB88320;

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_SFD, S_DATA, S_PAD, S_FCS, S_IPG
    } state_t;

    typedef enum logic [2:0] {
        GO_NONE, GO_DATA, GO_PAD, GO_FCS, GO_IPG
    } go_t;

    function automatic logic [31:0] crc_nib(input logic [31:0] c, input logic [3:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 4; i++) begin
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        end
        return r;
    endfunction

    state_t              state_q, state_d;
    go_t                 go_s;
    logic                send_prev_q, send_prev_d;
    logic                ready_q, ready_d;
    logic                done_q, done_d;
    logic [BUFFER_W-1:0] addr_q, addr_d;
    logic                tx_en_q, tx_en_d;
    logic [3:0]          tx_data_q, tx_data_d;
    logic [10:0]         nbytes_q, nbytes_d;
    logic                crc_en_q, crc_en_d;
    logic [10:0]         len_q, len_d;
    logic [10:0]         cnt_q, cnt_d;
    logic                hi_q, hi_d;
    logic [7:0]          byte_q, byte_d;
    logic [31:0]         crc_q, crc_d;
    logic [10:0]         next_cnt_s;
    logic [10:0]         len_s;

    assign next_cnt_s = cnt_q + 11'd1;

    // Payload target: short CRC frames are padded up to MIN_LEN.
    always_comb begin
        if (crc_en_i && (nbytes_i < MIN_LEN_W)) begin
            len_s = MIN_LEN_W;
        end else begin
            len_s = nbytes_i;
        end
    end

    // Next-state and next-output logic. cnt_q counts preamble nibbles, sent
    // bytes, FCS nibbles or gap cycles depending on state; hi_q marks that the
    // high nibble of the current byte is still to go.
    always_comb begin
        state_d     = state_q;
        send_prev_d = send_i;
        ready_d     = ready_q;
        done_d      = 1'b0;
        addr_d      = addr_q;
        tx_en_d     = tx_en_q;
        tx_data_d   = tx_data_q;
        nbytes_d    = nbytes_q;
        crc_en_d    = crc_en_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        byte_d      = byte_q;
        crc_d       = crc_q;
        go_s        = GO_NONE;

        case (state_q)
            S_IDLE: begin
                tx_en_d   = 1'b0;
                tx_data_d = 4'h0;
                ready_d   = 1'b1;
                if (send_i && !send_prev_q && ready_q) begin
                    nbytes_d  = nbytes_i;
                    crc_en_d  = crc_en_i;
                    len_d     = len_s;
                    crc_d     = 32'hFFFFFFFF;
                    addr_d    = {BUFFER_W{1'b0}};
                    cnt_d     = 11'd0;
                    state_d   = S_PRE;
                    tx_en_d   = 1'b1;
                    tx_data_d = 4'h5;
                    ready_d   = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PRE: begin
                if (cnt_q == 11'd14) begin
                    state_d   = S_SFD;
                    tx_data_d = 4'hD;
                    cnt_d     = 11'd0;
                end else begin
                    cnt_d     = next_cnt_s;
                    tx_data_d = 4'h5;
                end
            end
            S_SFD: begin
                if (nbytes_q != 11'd0) begin
                    go_s = GO_DATA;
                end else if (len_q != 11'd0) begin
                    go_s = GO_PAD;
                end else if (crc_en_q) begin
                    go_s = GO_FCS;
                end else begin
                    go_s = GO_IPG;
                end
            end
            S_DATA: begin
                if (hi_q) begin
                    tx_data_d = byte_q[7:4];
                    crc_d     = crc_nib(crc_q, byte_q[7:4]);
                    hi_d      = 1'b0;
                end else begin
                    cnt_d = next_cnt_s;
                    if (next_cnt_s < nbytes_q) begin
                        go_s = GO_DATA;
                    end else if (next_cnt_s < len_q) begin
                        go_s = GO_PAD;
                    end else if (crc_en_q) begin
                        go_s = GO_FCS;
                    end else begin
                        go_s = GO_IPG;
                    end
                end
            end
            S_PAD: begin
                if (hi_q) begin
                    tx_data_d = 4'h0;
                    crc_d     = crc_nib(crc_q, 4'h0);
                    hi_d      = 1'b0;
                end else begin
                    cnt_d = next_cnt_s;
                    if (next_cnt_s < len_q) begin
                        go_s = GO_PAD;
                    end else begin
                        go_s = GO_FCS;
                    end
                end
            end
            S_FCS: begin
                if (cnt_q == 11'd7) begin
                    go_s = GO_IPG;
                end else begin
                    cnt_d     = next_cnt_s;
                    tx_data_d = ~crc_q[3:0];
                    crc_d     = {4'h0, crc_q[31:4]};
                end
            end
            S_IPG: begin
                if (cnt_q == IPG_LAST) begin
                    state_d = S_IDLE;
                    ready_d = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = next_cnt_s;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The buffered byte is latched on the same edge the address advances.
        case (go_s)
            GO_DATA: begin
                state_d   = S_DATA;
                tx_data_d = data_i[3:0];
                byte_d    = data_i;
                addr_d    = addr_q + BUFFER_W'(1);
                hi_d      = 1'b1;
                crc_d     = crc_nib(crc_q, data_i[3:0]);
            end
            GO_PAD: begin
                state_d   = S_PAD;
                tx_data_d = 4'h0;
                hi_d      = 1'b1;
                crc_d     = crc_nib(crc_q, 4'h0);
            end
            GO_FCS: begin
                state_d   = S_FCS;
                tx_data_d = ~crc_q[3:0];
                crc_d     = {4'h0, crc_q[31:4]};
                cnt_d     = 11'd0;
            end
            GO_IPG: begin
                state_d   = S_IPG;
                tx_en_d   = 1'b0;
                tx_data_d = 4'h0;
                cnt_d     = 11'd0;
            end
            default: begin
                byte_d = byte_d;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q     <= S_IDLE;
            send_prev_q <= 1'b1;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            addr_q      <= {BUFFER_W{1'b0}};
            tx_en_q     <= 1'b0;
            tx_data_q   <= 4'h0;
            nbytes_q    <= 11'd0;
            crc_en_q    <= 1'b0;
            len_q       <= 11'd0;
            cnt_q       <= 11'd0;
            hi_q        <= 1'b0;
            byte_q      <= 8'h00;
            crc_q       <= 32'hFFFFFFFF;
        end else begin
            state_q     <= state_d;
            send_prev_q <= send_prev_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            addr_q      <= addr_d;
            tx_en_q     <= tx_en_d;
            tx_data_q   <= tx_data_d;
            nbytes_q    <= nbytes_d;
            crc_en_q    <= crc_en_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            byte_q      <= byte_d;
            crc_q       <= crc_d;
        end
    end

    assign ready_o   = ready_q;
    assign done_o    = done_q;
    assign addr_o    = addr_q;
    assign tx_en_o   = tx_en_q;
    assign tx_data_o = tx_data_q;

endmodule

// File: tb/tb_iob_eth_mii_tx_framer.sv
// Directed bench for iob_eth_mii_tx_framer: one instance without padding
// (wide buffer) and one with MIN_LEN=60 on a 16-byte buffer for wrap cases.
module tb_iob_eth_mii_tx_framer;

    logic        clk = 1'b0;
    logic        rstn;
    logic        send_a, send_b;
    logic [10:0] nbytes;
    logic        crc_en;
    logic        ready_a, done_a, tx_en_a, ready_b, done_b, tx_en_b;
    logic [10:0] addr_a;
    logic [3:0]  addr_b;
    logic [7:0]  data_a, data_b;
    logic [3:0]  tx_data_a, tx_data_b;
    logic [7:0]  mem_a [0:2047];
    logic [7:0]  mem_b [0:15];

    logic        sel;
    logic        tx_en_m, ready_m, done_m;
    logic [3:0]  tx_data_m;
    logic [10:0] addr_m;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    logic [3:0]  cap[$];
    logic [3:0]  exp_q[$];
    int          en_cyc, ipg_cyc, done_cnt, rises, t_first, t_last;
    int          max_addr;
    logic        timed_out, first_ok;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read TX buffer models
    always @(posedge clk) begin
        data_a <= mem_a[addr_a];
        data_b <= mem_b[addr_b];
    end

    assign tx_en_m   = sel ? tx_en_b : tx_en_a;
    assign ready_m   = sel ? ready_b : ready_a;
    assign done_m    = sel ? done_b : done_a;
    assign tx_data_m = sel ? tx_data_b : tx_data_a;
    assign addr_m    = sel ? {7'd0, addr_b} : addr_a;

    iob_eth_mii_tx_framer #(.BUFFER_W(11), .MIN_LEN(0), .IPG_CYC(24)) dut_a (
        .clk_i(clk), .rstn_i(rstn), .send_i(send_a), .nbytes_i(nbytes), .crc_en_i(crc_en),
        .ready_o(ready_a), .done_o(done_a), .addr_o(addr_a), .data_i(data_a),
        .tx_en_o(tx_en_a), .tx_data_o(tx_data_a));

    iob_eth_mii_tx_framer #(.BUFFER_W(4), .MIN_LEN(60), .IPG_CYC(24)) dut_b (
        .clk_i(clk), .rstn_i(rstn), .send_i(send_b), .nbytes_i(nbytes), .crc_en_i(crc_en),
        .ready_o(ready_b), .done_o(done_b), .addr_o(addr_b), .data_i(data_b),
        .tx_en_o(tx_en_b), .tx_data_o(tx_data_b));

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ b[i]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    function automatic int first_diff();
        if (cap.size() != exp_q.size()) return -2;
        foreach (cap[i]) if (cap[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    task automatic set_send(input logic s, input logic v);
        if (s) send_b = v;
        else   send_a = v;
    endtask

    task automatic push_pre();
        for (int i = 0; i < 15; i++) exp_q.push_back(4'h5);
        exp_q.push_back(4'hD);
    endtask

    task automatic build_exp(input logic s, input logic [10:0] nb, input logic ce);
        int depth, minlen, len;
        logic [31:0] c;
        logic [7:0]  b;
        depth  = s ? 16 : 2048;
        minlen = s ? 60 : 0;
        len    = (ce && int'(nb) < minlen) ? minlen : int'(nb);
        exp_q.delete();
        push_pre();
        c = 32'hFFFFFFFF;
        for (int k = 0; k < len; k++) begin
            if (k < int'(nb)) b = s ? mem_b[k % depth] : mem_a[k % depth];
            else              b = 8'h00;
            exp_q.push_back(b[3:0]);
            exp_q.push_back(b[7:4]);
            c = crc_byte(c, b);
        end
        if (ce) begin
            c = ~c;
            for (int i = 0; i < 8; i++) exp_q.push_back(c[4*i +: 4]);
        end
    endtask

    // mode 0: send pulses; 1: held high; 2: held, re-toggled while busy
    task automatic run_frame(input logic s, input logic [10:0] nb, input logic ce, input int mode);
        logic prev_en;
        sel = s; nbytes = nb; crc_en = ce;
        set_send(s, 1'b0);
        @(negedge clk);
        set_send(s, 1'b1);
        cap.delete();
        en_cyc = 0; ipg_cyc = 0; done_cnt = 0; rises = 0; max_addr = 0;
        timed_out = 1'b1; first_ok = 1'b0; prev_en = 1'b0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (c == 0) first_ok = (tx_en_m === 1'b1) && (ready_m === 1'b0);
            if (mode == 0 && c == 0) set_send(s, 1'b0);
            if (mode == 2 && c == 5) set_send(s, 1'b0);
            if (mode == 2 && c == 6) set_send(s, 1'b1);
            if (done_m === 1'b1) done_cnt++;
            if (tx_en_m === 1'b1) begin
                cap.push_back(tx_data_m);
                en_cyc++;
                if (!prev_en) begin
                    rises++;
                    if (rises == 1) t_first = cyc;
                end
                t_last = cyc;
                if (int'(addr_m) > max_addr) max_addr = int'(addr_m);
            end else if (ready_m === 1'b1) begin
                timed_out = 1'b0;
                break;
            end else begin
                ipg_cyc++;
            end
            prev_en = tx_en_m;
        end
        @(negedge clk);
        if (done_m === 1'b1) done_cnt++;
    endtask

    task automatic test_reset();
        rstn = 1'b0; send_a = 1'b1; send_b = 1'b0; sel = 1'b0;
        nbytes = 11'd5; crc_en = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (ready_a !== 1'b1 || ready_b !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b/%b want 1/1", ready_a, ready_b); end
        vectors++; if (done_a !== 1'b0 || done_b !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b/%b want 0/0", done_a, done_b); end
        vectors++; if (addr_a !== 11'd0 || addr_b !== 4'd0) begin miscompares++; $display("FAIL reset_addr: got %h/%h want 0/0", addr_a, addr_b); end
        vectors++; if (tx_en_a !== 1'b0 || tx_data_a !== 4'h0) begin miscompares++; $display("FAIL reset_tx: got en=%b d=%h want 0/0", tx_en_a, tx_data_a); end
        rstn = 1'b1;
        repeat (4) @(negedge clk);
        vectors++; if (tx_en_a !== 1'b0 || ready_a !== 1'b1) begin miscompares++; $display("FAIL reset_held_send: got en=%b rdy=%b want 0/1", tx_en_a, ready_a); end
        send_a = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [31:0] fcs;
        int d;
        for (int k = 0; k < 9; k++) mem_a[k] = 8'h31 + 8'(k);
        exp_q.delete();
        push_pre();
        for (int k = 0; k < 9; k++) begin
            exp_q.push_back(4'h1 + 4'(k));
            exp_q.push_back(4'h3);
        end
        fcs = 32'hCBF43926;
        for (int i = 0; i < 8; i++) exp_q.push_back(fcs[4*i +: 4]);
        run_frame(1'b0, 11'd9, 1'b1, 0);
        vectors++; if (timed_out !== 1'b0) begin miscompares++; $display("FAIL basic_timeout: ready never returned"); end
        vectors++; if (first_ok !== 1'b1) begin miscompares++; $display("FAIL basic_accept: got %b want 1", first_ok); end
        vectors++; if (en_cyc != 42) begin miscompares++; $display("FAIL basic_en_len: got %0d want 42", en_cyc); end
        d = first_diff();
        vectors++; if (d != -1) begin miscompares++; $display("FAIL basic_stream: diff at %0d (size %0d want %0d)", d, cap.size(), exp_q.size()); end
        vectors++; if (ipg_cyc != 24 || done_cnt != 1) begin miscompares++; $display("FAIL basic_ipg: got gap=%0d done=%0d want 24/1", ipg_cyc, done_cnt); end
    endtask

    task automatic test_padding();
        int d;
        build_exp(1'b1, 11'd10, 1'b1);
        run_frame(1'b1, 11'd10, 1'b1, 0);
        vectors++; if (en_cyc != 144) begin miscompares++; $display("FAIL pad_en_len: got %0d want 144", en_cyc); end
        d = first_diff();
        vectors++; if (d != -1) begin miscompares++; $display("FAIL pad_stream: diff at %0d (size %0d want %0d)", d, cap.size(), exp_q.size()); end
        vectors++; if (max_addr > 10) begin miscompares++; $display("FAIL pad_addr_max: got %0d want <=10", max_addr); end
        vectors++; if (timed_out !== 1'b0 || done_cnt != 1) begin miscompares++; $display("FAIL pad_done: got to=%b done=%0d want 0/1", timed_out, done_cnt); end
    endtask

    task automatic test_no_crc();
        int d;
        for (int k = 0; k < 4; k++) mem_a[k] = 8'hC5 ^ 8'(k * 17);
        build_exp(1'b0, 11'd4, 1'b0);
        run_frame(1'b0, 11'd4, 1'b0, 0);
        vectors++; if (en_cyc != 24) begin miscompares++; $display("FAIL nocrc_en_len: got %0d want 24", en_cyc); end
        d = first_diff();
        vectors++; if (d != -1) begin miscompares++; $display("FAIL nocrc_stream: diff at %0d (size %0d want %0d)", d, cap.size(), exp_q.size()); end
        vectors++; if (ipg_cyc != 24) begin miscompares++; $display("FAIL nocrc_ipg: got %0d want 24", ipg_cyc); end
        vectors++; if (done_cnt != 1 || timed_out !== 1'b0) begin miscompares++; $display("FAIL nocrc_done: got done=%0d to=%b want 1/0", done_cnt, timed_out); end
    endtask

    task automatic test_back_to_back();
        int t_last1, extra;
        run_frame(1'b0, 11'd2, 1'b0, 2);
        t_last1 = t_last;
        vectors++; if (rises != 1 || en_cyc != 20) begin miscompares++; $display("FAIL b2b_single: got rises=%0d en=%0d want 1/20", rises, en_cyc); end
        extra = 0;
        repeat (10) begin
            @(negedge clk);
            if (tx_en_a !== 1'b0) extra++;
        end
        vectors++; if (extra != 0) begin miscompares++; $display("FAIL b2b_held: got %0d tx_en cycles want 0", extra); end
        run_frame(1'b0, 11'd2, 1'b0, 0);
        vectors++; if (first_ok !== 1'b1 || en_cyc != 20) begin miscompares++; $display("FAIL b2b_second: got ok=%b en=%0d want 1/20", first_ok, en_cyc); end
        vectors++; if (t_first - t_last1 - 1 < 24) begin miscompares++; $display("FAIL b2b_gap: got %0d want >=24", t_first - t_last1 - 1); end
    endtask

    task automatic test_mid_reset();
        int seen;
        sel = 1'b0; nbytes = 11'd20; crc_en = 1'b0;
        send_a = 1'b0;
        @(negedge clk);
        send_a = 1'b1;
        repeat (20) @(negedge clk);
        vectors++; if (tx_en_a !== 1'b1) begin miscompares++; $display("FAIL midrst_busy: got %b want 1", tx_en_a); end
        rstn = 1'b0;
        @(negedge clk);
        vectors++; if (tx_en_a !== 1'b0 || ready_a !== 1'b1) begin miscompares++; $display("FAIL midrst_state: got en=%b rdy=%b want 0/1", tx_en_a, ready_a); end
        vectors++; if (addr_a !== 11'd0 || tx_data_a !== 4'h0) begin miscompares++; $display("FAIL midrst_addr: got a=%h d=%h want 0/0", addr_a, tx_data_a); end
        rstn = 1'b1;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (tx_en_a !== 1'b0) seen++;
        end
        vectors++; if (seen != 0) begin miscompares++; $display("FAIL midrst_no_restart: got %0d tx_en cycles want 0", seen); end
        run_frame(1'b0, 11'd20, 1'b0, 0);
        vectors++; if (first_ok !== 1'b1 || en_cyc != 56) begin miscompares++; $display("FAIL midrst_resend: got ok=%b en=%0d want 1/56", first_ok, en_cyc); end
    endtask

    task automatic test_wrap_empty();
        int d;
        build_exp(1'b1, 11'd18, 1'b0);
        run_frame(1'b1, 11'd18, 1'b0, 0);
        vectors++; if (en_cyc != 52) begin miscompares++; $display("FAIL wrap_en_len: got %0d want 52", en_cyc); end
        d = first_diff();
        vectors++; if (d != -1) begin miscompares++; $display("FAIL wrap_stream: diff at %0d (size %0d want %0d)", d, cap.size(), exp_q.size()); end
        vectors++; if (addr_b !== 4'd2) begin miscompares++; $display("FAIL wrap_addr_end: got %0d want 2", addr_b); end
        build_exp(1'b0, 11'd0, 1'b0);
        run_frame(1'b0, 11'd0, 1'b0, 0);
        vectors++; if (en_cyc != 16) begin miscompares++; $display("FAIL empty_en_len: got %0d want 16", en_cyc); end
        d = first_diff();
        vectors++; if (d != -1) begin miscompares++; $display("FAIL empty_stream: diff at %0d (size %0d want %0d)", d, cap.size(), exp_q.size()); end
        vectors++; if (ipg_cyc != 24 || done_cnt != 1) begin miscompares++; $display("FAIL empty_ipg: got gap=%0d done=%0d want 24/1", ipg_cyc, done_cnt); end
    endtask

    initial begin
        for (int k = 0; k < 2048; k++) mem_a[k] = 8'(k * 7 + 3);
        for (int k = 0; k < 16; k++) mem_b[k] = 8'hA0 + 8'(k);
        test_reset();
        test_basic();
        test_padding();
        test_no_crc();
        test_back_to_back();
        test_mid_reset();
        test_wrap_empty();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
